sv_lut_access_ctrl: RTL and testbench
=====================================

# sv_lut_access_ctrl

Sequencer/arbiter for the shared 7-bit-address, 1-bit-data combinational lookup table used in the stereovision chip-3 datapath. Multiplexes up to NREQ requesters onto the single table port with round-robin arbitration and returns each registered result one cycle after acceptance. Also provides a self-check sweep mode that scans all 128 table entries and reports the count of ones. Sits between the chip-3 control logic and the lookup table, which is external and purely combinational.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- ADDR_W, 7: table address width; depth is 2**ADDR_W.

Ports:
- tm3_clk_v0  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester lookup request.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-hot, registered; marks the requester whose result is on rsp_data.
- rsp_data  out  1  registered table result.
- lut_addr  out  ADDR_W  address driven to the table.
- lut_data  in  1  table output, combinational from lut_addr.
- sweep_start  in  1  one-cycle pulse that starts a full-table sweep.
- sweep_done  out  1  one-cycle pulse when the sweep completes.
- sweep_ones  out  ADDR_W+1  count of 1 entries from the last sweep.
- busy  out  1  high while the state is not IDLE.

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE:
  - If sweep_start is high, next state is SWEEP, all req_ready are 0 that cycle, and sweep_ones clears to 0. The sweep has priority over requests.
  - Otherwise the round-robin arbiter grants the lowest index at or after rr_ptr (circularly) with req_valid high.
  - req_ready is combinational from req_valid and rr_ptr.
  - lut_addr is the granted requester's address, or 0 when there is no grant.
  - On acceptance: rsp_valid <= grant, rsp_data <= lut_data, and rr_ptr <= (grant index + 1) mod NREQ.
  - With no acceptance: rsp_valid <= 0, and rsp_data holds its value.
- SWEEP:
  - Counter cnt runs from 0 to 2**ADDR_W-1, one entry per cycle; lut_addr = cnt.
  - sweep_ones += lut_data each cycle.
  - req_ready = 0 and rsp_valid = 0 throughout.
  - After cnt = max the next state is DONE; the counter wraps to 0.
- DONE: sweep_done = 1 for exactly this one cycle, then IDLE. sweep_start is ignored in SWEEP and DONE.
- sweep_ones holds its value until the next accepted sweep_start.
- Width rule: sweep_ones is ADDR_W+1 bits, so an all-ones table gives 128 with no overflow.
- Reset values: state IDLE, rr_ptr 0, cnt 0, rsp_valid 0, rsp_data 0, sweep_done 0, sweep_ones 0, busy 0.
- Reset mid-sweep: the sweep is aborted, no sweep_done pulse is produced, and sweep_ones reads 0.

## Timing
- Request latency is 1 cycle: accepted at edge k, so rsp_valid and rsp_data are valid after edge k+1, for one cycle.
- Throughput is one lookup per cycle. There is no response backpressure; requesters must sample rsp_data while their rsp_valid bit is high.
- A requester holding req_valid with req_ready low must keep req_addr stable.
- Sweep: sweep_start sampled at edge k drives addresses 0..127 in cycles k+1..k+128. sweep_done is high in cycle k+129 and sweep_ones is final at that cycle. busy is high from k+1 through k+129.
- Simultaneous sweep_start and req_valid in IDLE: no request is accepted. Those requests are served after DONE, starting from the unchanged rr_ptr.

## Structure
- Package sv_lut_pkg holds ADDR_W default, LUT_DEPTH, the state enum (IDLE/SWEEP/DONE), and a function returning the ceil-log2 pointer width.
- Sub-module sv_rr_arb (parameter NREQ) takes req_valid and rr_ptr and produces a one-hot grant and the grant index, combinationally.
- The top level contains the FSM, sweep counter, accumulator, address mux and response registers.

## Test plan
- Reset: assert rst_n low asynchronously between clock edges -> all outputs are 0 immediately and busy = 0; after release, lut_addr = 0.
- Single request: bench stub LUT = addr[0]; req_valid = 4'b0100 with address 7'h05 -> req_ready = 4'b0100; next cycle rsp_valid = 4'b0100 and rsp_data = 1.
- Fairness: req_valid = 4'b1111 held for 5 cycles -> grants 0, 1, 2, 3, 0; each rsp_valid bit appears one cycle after its grant.
- Sweep: stub LUT = addr[0], pulse sweep_start at edge k -> sweep_done only at k+129, sweep_ones = 64, req_ready = 0 throughout. Repeat with an all-ones stub -> sweep_ones = 128.
- Collision: sweep_start and req_valid = 4'b0010 in the same cycle -> no acceptance that cycle; requester 1 is accepted in the first cycle after DONE.
- Abort: rst_n low while lut_addr = 50 during a sweep -> state IDLE, sweep_ones = 0, and no sweep_done pulse.

Source files
------------

// File: rtl/sv_lut_pkg.sv
// Shared definitions for the chip-3 lookup-table sequencer: table geometry,
// the controller state encoding and a pointer-width helper.
package sv_lut_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int LUT_DEPTH  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of a pointer able to index n requesters; never narrower than 1 bit.
  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sv_rr_arb.sv
// Combinational round-robin arbiter: grants the first valid requester found
// when scanning circularly upward from i_rr_ptr.
module sv_rr_arb
  import sv_lut_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  i_req_valid,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [PTR_W-1:0] o_grant_idx,
  output logic             o_grant_any
);

  logic [PTR_W:0] w_sum;

  // NOTE: every signal written here gets a default first, so no path through
  // the loop can leave a value unassigned and infer a latch.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    w_sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (PTR_W + 1)'(k);
      if (w_sum >= (PTR_W + 1)'(NREQ)) w_sum = w_sum - (PTR_W + 1)'(NREQ);
      if (!o_grant_any && i_req_valid[w_sum[PTR_W-1:0]]) begin
        o_grant_any                  = 1'b1;
        o_grant[w_sum[PTR_W-1:0]]    = 1'b1;
        o_grant_idx                  = w_sum[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sv_lut_access_ctrl.sv
// Shares one combinational lookup table between NREQ requesters with
// round-robin arbitration, and offers a full-table sweep that counts ones.
module sv_lut_access_ctrl
  import sv_lut_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     tm3_clk_v0,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic                     rsp_data,
  output logic [ADDR_W-1:0]        lut_addr,
  input  logic                     lut_data,
  input  logic                     sweep_start,
  output logic                     sweep_done,
  output logic [ADDR_W:0]          sweep_ones,
  output logic                     busy
);

  localparam int PTR_W = ptr_width(NREQ);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W:0]   r_ones;
  logic [NREQ-1:0]   r_rsp_valid;
  logic              r_rsp_data;

  logic [NREQ-1:0]   w_grant;
  logic [PTR_W-1:0]  w_grant_idx;
  logic              w_grant_any;
  logic              w_accept;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [ADDR_W-1:0] w_addr_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign w_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  sv_rr_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  // A sweep request in IDLE wins over every pending lookup that cycle.
  assign w_accept   = (r_state == ST_IDLE) && !sweep_start && w_grant_any;
  assign req_ready  = w_accept ? w_grant : '0;
  assign w_next_ptr = (w_grant_idx == PTR_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    lut_addr = '0;
    if (r_state == ST_SWEEP)  lut_addr = r_cnt;
    else if (w_accept)        lut_addr = w_addr_arr[w_grant_idx];
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge tm3_clk_v0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_ones      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (sweep_start) begin
            r_state <= ST_SWEEP;
            r_ones  <= '0;
          end else if (w_grant_any) begin
            r_rsp_valid <= w_grant;
            r_rsp_data  <= lut_data;
            r_rr_ptr    <= w_next_ptr;
          end
        end
        ST_SWEEP: begin
          r_ones <= r_ones + (ADDR_W + 1)'(lut_data);
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_MAX) r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign sweep_done = (r_state == ST_DONE);
  assign sweep_ones = r_ones;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sv_lut_access_ctrl.sv
// Randomized bench for sv_lut_access_ctrl against a cycle-count reference
// model, plus directed reset, fairness, sweep, collision and abort cases.
module tb_sv_lut_access_ctrl;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int AW_ALL = NREQ * ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [AW_ALL-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_data;
  logic [ADDR_W-1:0] lut_addr;
  logic              lut_data;
  logic              sweep_start;
  logic              sweep_done;
  logic [ADDR_W:0]   sweep_ones;
  logic              busy;

  always #5 clk = ~clk;

  sv_lut_access_ctrl #(.NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
    .tm3_clk_v0  (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .sweep_start (sweep_start),
    .sweep_done  (sweep_done),
    .sweep_ones  (sweep_ones),
    .busy        (busy)
  );

  // Table stub: 0 = addr[0], 1 = all ones, 2 = random contents.
  int   lut_mode;
  logic lut_tab [DEPTH];

  always_comb begin
    lut_data = 1'b0;
    case (lut_mode)
      0:       lut_data = lut_addr[0];
      1:       lut_data = 1'b1;
      default: lut_data = lut_tab[lut_addr];
    endcase
  end

  function automatic logic lut_ref(input int a);
    if (lut_mode == 0) return logic'(a % 2);
    if (lut_mode == 1) return 1'b1;
    return lut_tab[a];
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_sweep_cyc is 0 when idle, 1..DEPTH while scanning
  // entry m_sweep_cyc-1, and DEPTH+1 in the completion cycle.
  int              m_ptr;
  int              m_sweep_cyc;
  int              m_ones;
  logic [NREQ-1:0] m_rsp_valid;
  logic            m_rsp_data;

  task automatic model_reset();
    m_ptr       = 0;
    m_sweep_cyc = 0;
    m_ones      = 0;
    m_rsp_valid = '0;
    m_rsp_data  = 1'b0;
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [AW_ALL-1:0] a, input logic s);
    int              g;
    int              e_addr;
    int              idx;
    logic [NREQ-1:0] e_ready;
    logic            e_lut;
    @(negedge clk);
    check("rsp_valid",  32'(rsp_valid),  32'(m_rsp_valid));
    check("rsp_data",   32'(rsp_data),   32'(m_rsp_data));
    check("sweep_done", 32'(sweep_done), 32'(m_sweep_cyc == DEPTH + 1));
    check("busy",       32'(busy),       32'(m_sweep_cyc != 0));
    check("sweep_ones", 32'(sweep_ones), 32'(m_ones));
    req_valid   = v;
    req_addr    = a;
    sweep_start = s;
    #1;
    g = -1;
    e_addr = 0;
    e_ready = '0;
    if (m_sweep_cyc == 0 && !s) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      e_addr = int'(a[g*ADDR_W +: ADDR_W]);
    end
    if (m_sweep_cyc >= 1 && m_sweep_cyc <= DEPTH) e_addr = m_sweep_cyc - 1;
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("lut_addr",  32'(lut_addr),  32'(e_addr));
    e_lut = lut_ref(e_addr);
    @(posedge clk);
    m_rsp_valid = '0;
    if (m_sweep_cyc == 0) begin
      if (s) begin
        m_sweep_cyc = 1;
        m_ones = 0;
      end else if (g >= 0) begin
        m_rsp_valid = e_ready;
        m_rsp_data  = e_lut;
        m_ptr       = (g + 1) % NREQ;
      end
    end else if (m_sweep_cyc <= DEPTH) begin
      m_ones += int'(e_lut);
      m_sweep_cyc++;
    end else begin
      m_sweep_cyc = 0;
    end
  endtask

  task automatic rand_step(input logic allow_sweep);
    logic [AW_ALL-1:0] a;
    a = AW_ALL'($urandom);
    step(NREQ'($urandom), a, allow_sweep && ($urandom_range(0, 63) == 0));
  endtask

  task automatic run_sweep(input int exp_ones);
    step('0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW_ALL-1:0] a;
      a = AW_ALL'($urandom);
      step(NREQ'($urandom), a, logic'($urandom_range(0, 1)));
    end
    step('0, '0, 1'b0);
    #1 check("sweep_total", 32'(sweep_ones), 32'(exp_ones));
  endtask

  task automatic reset_between_edges();
    req_valid   = '0;
    sweep_start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_data",   32'(rsp_data),   32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_sweep_ones", 32'(sweep_ones), 32'd0);
    check("rst_lut_addr",   32'(lut_addr),   32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW_ALL-1:0] a;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    sweep_start = 1'b0;
    lut_mode    = 0;
    for (int i = 0; i < DEPTH; i++) lut_tab[i] = logic'($urandom_range(0, 1));
    model_reset();
    #12;
    check("init_busy", 32'(busy), 32'd0);
    check("init_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_lut_addr", 32'(lut_addr), 32'd0);

    // Single request from requester 2 at odd address 5.
    a = '0;
    a[2*ADDR_W +: ADDR_W] = 7'h05;
    step(4'b0100, a, 1'b0);
    #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'b0100);
    check("single_rsp_data",  32'(rsp_data),  32'd1);

    // Fairness: after the grant to 2 the pointer sits at 3, so rotate from 3;
    // reset first so the sequence starts from pointer 0.
    reset_between_edges();
    for (int i = 0; i < 5; i++) begin
      a = AW_ALL'($urandom);
      step(4'b1111, a, 1'b0);
      #1 check("fair_grant", 32'(rsp_valid), 32'(4'b0001 << (i % 4)));
    end

    lut_mode = 0;
    run_sweep(64);
    lut_mode = 1;
    run_sweep(128);

    // Collision: requester 1 waits out the whole sweep.
    lut_mode = 0;
    a = '0;
    a[1*ADDR_W +: ADDR_W] = 7'h2B;
    step(4'b0010, a, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(4'b0010, a, 1'b0);
    step(4'b0010, a, 1'b0);
    #1;
    check("collide_rsp_valid", 32'(rsp_valid), 32'b0010);
    check("collide_rsp_data",  32'(rsp_data),  32'd1);

    lut_mode = 2;
    for (int i = 0; i < 600; i++) rand_step(1'b1);
    for (int i = 0; i < DEPTH + 2; i++) rand_step(1'b0);

    // Abort a sweep while entry 50 is on the table port.
    lut_mode = 1;
    step('0, '0, 1'b1);
    for (int i = 0; i < 50; i++) step('0, '0, 1'b0);
    @(negedge clk);
    #1 check("abort_lut_addr", 32'(lut_addr), 32'd50);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",       32'(busy),       32'd0);
    check("abort_sweep_ones", 32'(sweep_ones), 32'd0);
    check("abort_sweep_done", 32'(sweep_done), 32'd0);
    check("abort_lut_addr0",  32'(lut_addr),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 10; i++) step('0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
